// File: rtl/fft_wb_feeder_pkg.sv
// fft_wb_feeder_pkg: shared FSM state type and FFT slave register encodings.
package fft_wb_feeder_pkg;
  typedef enum logic [2:0] {IDLE, START, FEED, POLL_WAIT, POLL, DRAIN, CLEAR} state_e;
  localparam logic [31:0] CTRL_ENABLE = 32'h1;
  localparam logic [31:0] CTRL_CLEAR = 32'h2;
  localparam int STATUS_DONE_BIT = 0;
endpackage

// File: rtl/fft_wb_feeder_if.sv
// fft_wb_feeder_if: Wishbone classic bus between the feeder (master) and the FFT slave.
interface fft_wb_feeder_if #(
  parameter int WB_Width = 32,
  parameter int Adress_wordwidth = 32
);
  logic [Adress_wordwidth-1:0] M_ADR_O;
  logic [WB_Width-1:0] M_DAT_O;
  logic [WB_Width-1:0] M_DAT_I;
  logic M_STB_O;
  logic M_CYC_O;
  logic M_WE_O;
  logic M_ACK_I;
  modport master (output M_ADR_O, M_DAT_O, M_STB_O, M_CYC_O, M_WE_O, input M_DAT_I, M_ACK_I);
  modport slave (input M_ADR_O, M_DAT_O, M_STB_O, M_CYC_O, M_WE_O, output M_DAT_I, M_ACK_I);
endinterface

// File: rtl/fft_wb_master_port.sv
// fft_wb_master_port: single-outstanding Wishbone transaction engine with a req/done handshake.
module fft_wb_master_port #(
  parameter int WB_Width = 32,
  parameter int Adress_wordwidth = 32
) (
  input  logic CLK_I,
  input  logic RST_I,
  input  logic req,
  input  logic req_we,
  input  logic [Adress_wordwidth-1:0] req_adr,
  input  logic [WB_Width-1:0] req_dat,
  output logic done,
  output logic [WB_Width-1:0] rdata,
  output logic port_busy,
  fft_wb_feeder_if.master bus
);
  logic stb_q, stb_d, we_q, we_d, gap_q, load;
  logic [Adress_wordwidth-1:0] adr_q, adr_d;
  logic [WB_Width-1:0] dat_q, dat_d;
  // gap_q covers the cycle after ACK so STB always idles at least one cycle
  assign port_busy = stb_q | gap_q;
  assign rdata = bus.M_DAT_I;
  assign bus.M_STB_O = stb_q;
  assign bus.M_CYC_O = stb_q;
  assign bus.M_WE_O = we_q;
  assign bus.M_ADR_O = adr_q;
  assign bus.M_DAT_O = dat_q;
  always_comb begin
    load = req && !port_busy;
    done = stb_q && bus.M_ACK_I;
    stb_d = stb_q ? !bus.M_ACK_I : load;
    we_d = load ? req_we : we_q;
    adr_d = load ? req_adr : adr_q;
    dat_d = load ? req_dat : dat_q;
  end
  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) begin
      stb_q <= 1'b0;
      we_q <= 1'b0;
      gap_q <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
    end else begin
      stb_q <= stb_d;
      we_q <= we_d;
      gap_q <= done;
      adr_q <= adr_d;
      dat_q <= dat_d;
    end
endmodule

// File: rtl/fft_wb_feeder.sv
// fft_wb_feeder: streams a frame into the FFT Wishbone slave, polls for completion,
// drains the results to an output stream and clears the core without CPU help.
module fft_wb_feeder
  import fft_wb_feeder_pkg::*;
#(
  parameter int WB_Width = 32,
  parameter int Adress_wordwidth = 32,
  parameter int N = 1024,
  parameter int Log2N = 10,
  parameter logic [Adress_wordwidth-1:0] BASE = '0,
  parameter int reg_control = 0,
  parameter int reg_data = 4,
  parameter int reg_status = 8,
  parameter int reg_memory = 12,
  parameter int POLL_GAP = 8
) (
  input  logic CLK_I,
  input  logic RST_I,
  fft_wb_feeder_if.master bus,
  input  logic s_valid,
  output logic s_ready,
  input  logic [WB_Width-1:0] s_data,
  output logic m_valid,
  input  logic m_ready,
  output logic [WB_Width-1:0] m_data,
  output logic busy,
  output logic frame_done,
  output logic [15:0] frame_count
);
  localparam logic [Adress_wordwidth-1:0] ADR_CTRL = Adress_wordwidth'(BASE + reg_control);
  localparam logic [Adress_wordwidth-1:0] ADR_DATA = Adress_wordwidth'(BASE + reg_data);
  localparam logic [Adress_wordwidth-1:0] ADR_STATUS = Adress_wordwidth'(BASE + reg_status);
  localparam logic [Adress_wordwidth-1:0] ADR_MEMORY = Adress_wordwidth'(BASE + reg_memory);
  localparam logic [Log2N-1:0] CNT_LAST = Log2N'(N - 1);
  localparam logic [Log2N-1:0] CNT_ONE = Log2N'(1);
  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);
  state_e state_q, state_d;
  logic [Log2N-1:0] cnt_q, cnt_d;
  logic [15:0] wcnt_q, wcnt_d, frame_count_q, frame_count_d;
  logic m_valid_q, m_valid_d, frame_done_q, frame_done_d;
  logic [WB_Width-1:0] m_data_q, m_data_d, rdata, req_dat;
  logic [Adress_wordwidth-1:0] req_adr;
  logic req, req_we, done, port_busy;
  fft_wb_master_port #(.WB_Width(WB_Width), .Adress_wordwidth(Adress_wordwidth)) u_port (
    .CLK_I(CLK_I), .RST_I(RST_I), .req(req), .req_we(req_we), .req_adr(req_adr), .req_dat(req_dat),
    .done(done), .rdata(rdata), .port_busy(port_busy), .bus(bus)
  );
  assign s_ready = (state_q == FEED) && !port_busy;
  assign m_valid = m_valid_q;
  assign m_data = m_data_q;
  assign busy = state_q != IDLE;
  assign frame_done = frame_done_q;
  assign frame_count = frame_count_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wcnt_d = wcnt_q;
    m_valid_d = m_valid_q;
    m_data_d = m_data_q;
    frame_done_d = 1'b0;
    frame_count_d = frame_count_q;
    req = 1'b0;
    req_we = 1'b0;
    req_adr = ADR_CTRL;
    req_dat = WB_Width'(CTRL_ENABLE);
    case (state_q)
      IDLE: state_d = s_valid ? START : IDLE;
      START: begin
        req = !port_busy;
        req_we = 1'b1;
        if (done) begin
          state_d = FEED;
          cnt_d = '0;
        end
      end
      FEED: begin
        req = s_valid && s_ready;
        req_we = 1'b1;
        req_adr = ADR_DATA;
        req_dat = s_data;
        if (done) begin
          cnt_d = cnt_q + CNT_ONE;
          wcnt_d = '0;
          state_d = (cnt_q == CNT_LAST) ? POLL_WAIT : FEED;
        end
      end
      POLL_WAIT: begin
        wcnt_d = wcnt_q + 16'd1;
        state_d = (wcnt_q == GAP_LAST) ? POLL : POLL_WAIT;
      end
      POLL: begin
        req = !port_busy;
        req_adr = ADR_STATUS;
        if (done) begin
          state_d = rdata[STATUS_DONE_BIT] ? DRAIN : POLL_WAIT;
          cnt_d = '0;
          wcnt_d = '0;
        end
      end
      DRAIN: begin
        // a held result blocks the next read so the slave index never runs ahead
        req = !port_busy && !m_valid_q;
        req_adr = ADR_MEMORY;
        if (done) begin
          m_valid_d = 1'b1;
          m_data_d = rdata;
        end
        if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          cnt_d = cnt_q + CNT_ONE;
          state_d = (cnt_q == CNT_LAST) ? CLEAR : DRAIN;
        end
      end
      CLEAR: begin
        req = !port_busy;
        req_we = 1'b1;
        req_dat = WB_Width'(CTRL_CLEAR);
        if (done) begin
          state_d = IDLE;
          frame_done_d = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wcnt_q <= '0;
      m_valid_q <= 1'b0;
      m_data_q <= '0;
      frame_done_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wcnt_q <= wcnt_d;
      m_valid_q <= m_valid_d;
      m_data_q <= m_data_d;
      frame_done_q <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
endmodule

// File: tb/tb_fft_wb_feeder.sv
// tb_fft_wb_feeder: directed bench for fft_wb_feeder against a behavioural FFT slave.
module tb_fft_wb_feeder;
  import fft_wb_feeder_pkg::*;
  localparam logic [31:0] B = 32'h100;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0, m_ready = 1'b0;
  logic [31:0] s_data = '0;
  logic s_ready, m_valid, busy, frame_done;
  logic [31:0] m_data;
  logic [15:0] frame_count;
  int compared = 0, mismatched = 0;
  int ack_delay = 0, wait_n = 0, rd_idx = 0, st_n = 0, cyc_n = 0, rise_q = 0, lg_n = 0;
  logic stb_prev = 1'b0;
  logic [31:0] lg_adr [64];
  logic [31:0] lg_dat [64];
  logic lg_we [64];
  int lg_rise [64];
  int lg_ack [64];
  always #5 clk = ~clk;
  fft_wb_feeder_if #(.WB_Width(32), .Adress_wordwidth(32)) bus ();
  fft_wb_feeder #(.WB_Width(32), .Adress_wordwidth(32), .N(8), .Log2N(3), .BASE(B), .POLL_GAP(2)) dut (
    .CLK_I(clk), .RST_I(rst_n), .bus(bus), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count)
  );
  always_comb begin
    bus.M_ACK_I = bus.M_STB_O && (wait_n >= ack_delay);
    bus.M_DAT_I = (bus.M_ADR_O == B + 32'd8) ? {31'd0, st_n >= 2} :
                  (bus.M_ADR_O == B + 32'd12) ? 32'h5A00_0000 + 32'(rd_idx) * 32'h0001_0003 : 32'hDEAD_BEEF;
  end
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    stb_prev <= bus.M_STB_O;
    if (bus.M_STB_O && !stb_prev) rise_q <= cyc_n;
    wait_n <= (bus.M_STB_O && !bus.M_ACK_I) ? wait_n + 1 : 0;
    if (bus.M_STB_O && bus.M_ACK_I) begin
      if (lg_n < 64) begin
        lg_adr[lg_n] <= bus.M_ADR_O;
        lg_we[lg_n] <= bus.M_WE_O;
        lg_dat[lg_n] <= bus.M_WE_O ? bus.M_DAT_O : bus.M_DAT_I;
        lg_rise[lg_n] <= stb_prev ? rise_q : cyc_n;
        lg_ack[lg_n] <= cyc_n;
      end
      lg_n <= lg_n + 1;
      if (!bus.M_WE_O && bus.M_ADR_O == B + 32'd12) rd_idx <= rd_idx + 1;
      if (!bus.M_WE_O && bus.M_ADR_O == B + 32'd8) st_n <= st_n + 1;
    end
  end

  task automatic send(input logic [31:0] d, output int hs);
    int n = 0;
    s_data = d;
    s_valid = 1'b1;
    while (!s_ready && n < 200) begin @(negedge clk); n++; end
    hs = cyc_n;
    compared++;
    if (s_ready !== 1'b1) begin mismatched++; $display("FAIL send_ready got=%b exp=1 data=%h", s_ready, d); end
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic test_reset;
    int n = 0;
    rst_n = 1'b0;
    s_valid = 1'b1;
    s_data = 32'h0001_0000;
    repeat (3) @(negedge clk);
    compared++;
    if ({bus.M_STB_O, bus.M_CYC_O, bus.M_WE_O} !== 3'b000) begin mismatched++; $display("FAIL reset_bus_ctrl got=%b exp=000", {bus.M_STB_O, bus.M_CYC_O, bus.M_WE_O}); end
    compared++;
    if ({bus.M_ADR_O, bus.M_DAT_O} !== 64'd0) begin mismatched++; $display("FAIL reset_adr_dat got=%h exp=0", {bus.M_ADR_O, bus.M_DAT_O}); end
    compared++;
    if ({s_ready, m_valid, busy, frame_done, m_data, frame_count} !== 52'd0) begin mismatched++; $display("FAIL reset_outputs got=%h exp=0", {s_ready, m_valid, busy, frame_done, m_data, frame_count}); end
    rst_n = 1'b1;
    while (!s_ready && n < 50) begin @(negedge clk); n++; end
    s_valid = 1'b0;
    compared++;
    if (s_ready !== 1'b1) begin mismatched++; $display("FAIL start_s_ready got=%b exp=1", s_ready); end
    compared++;
    if (lg_n !== 1) begin mismatched++; $display("FAIL start_count got=%0d exp=1", lg_n); end
    compared++;
    if ({lg_adr[0], lg_we[0], lg_dat[0]} !== {B, 1'b1, 32'h1}) begin mismatched++; $display("FAIL start_write got=%h/%b/%h exp=100/1/1", lg_adr[0], lg_we[0], lg_dat[0]); end
  endtask

  task automatic test_feed;
    int base = lg_n;
    int n = 0;
    int hs [8];
    for (int i = 0; i < 8; i++) send(32'(i + 1) << 16, hs[i]);
    while (lg_n != base + 8 && n < 50) begin @(negedge clk); n++; end
    compared++;
    if (dut.state_q !== POLL_WAIT) begin mismatched++; $display("FAIL feed_state got=%0d exp=%0d", dut.state_q, POLL_WAIT); end
    for (int i = 0; i < 8; i++) begin
      compared++;
      if ({lg_adr[base+i], lg_we[base+i], lg_dat[base+i]} !== {B + 32'd4, 1'b1, 32'(i + 1) << 16})
        begin mismatched++; $display("FAIL feed_write%0d got=%h/%b/%h exp=104/1/%h", i, lg_adr[base+i], lg_we[base+i], lg_dat[base+i], 32'(i + 1) << 16); end
      compared++;
      if (lg_rise[base+i] !== hs[i] + 1) begin mismatched++; $display("FAIL feed_stb_latency%0d got=%0d exp=%0d", i, lg_rise[base+i], hs[i] + 1); end
      if (i > 0) begin
        compared++;
        if (lg_rise[base+i] - lg_ack[base+i-1] < 2) begin mismatched++; $display("FAIL feed_stb_gap%0d got=%0d exp>=2", i, lg_rise[base+i] - lg_ack[base+i-1]); end
        compared++;
        if (hs[i] - hs[i-1] !== 3) begin mismatched++; $display("FAIL feed_ready_latency%0d got=%0d exp=3", i, hs[i] - hs[i-1]); end
      end
    end
  endtask

  task automatic test_poll;
    int base = lg_n;
    int n = 0;
    while (dut.state_q !== DRAIN && n < 200) begin @(negedge clk); n++; end
    compared++;
    if (dut.state_q !== DRAIN) begin mismatched++; $display("FAIL poll_state got=%0d exp=%0d", dut.state_q, DRAIN); end
    compared++;
    if (lg_n - base !== 3) begin mismatched++; $display("FAIL poll_reads got=%0d exp=3", lg_n - base); end
    for (int j = 0; j < 3; j++) begin
      compared++;
      if ({lg_adr[base+j], lg_we[base+j], lg_dat[base+j]} !== {B + 32'd8, 1'b0, (j == 2) ? 32'd1 : 32'd0})
        begin mismatched++; $display("FAIL poll_read%0d got=%h/%b/%h", j, lg_adr[base+j], lg_we[base+j], lg_dat[base+j]); end
      compared++;
      if (lg_rise[base+j] - lg_ack[base+j-1] < 3) begin mismatched++; $display("FAIL poll_gap%0d got=%0d exp>=3", j, lg_rise[base+j] - lg_ack[base+j-1]); end
    end
  endtask

  task automatic test_drain;
    int base = lg_n;
    logic [31:0] exp_d;
    for (int i = 0; i < 8; i++) begin
      int n = 0;
      exp_d = 32'h5A00_0000 + 32'(i) * 32'h0001_0003;
      while (!m_valid && n < 50) begin @(negedge clk); n++; end
      compared++;
      if ({m_valid, m_data} !== {1'b1, exp_d}) begin mismatched++; $display("FAIL drain_data%0d got=%b/%h exp=1/%h", i, m_valid, m_data, exp_d); end
      compared++;
      if (lg_n - base !== i + 1) begin mismatched++; $display("FAIL drain_reads%0d got=%0d exp=%0d", i, lg_n - base, i + 1); end
      compared++;
      if ({lg_adr[base+i], lg_we[base+i]} !== {B + 32'd12, 1'b0}) begin mismatched++; $display("FAIL drain_adr%0d got=%h/%b exp=10c/0", i, lg_adr[base+i], lg_we[base+i]); end
      if (i == 3) begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          compared++;
          if ({m_valid, m_data, bus.M_STB_O} !== {1'b1, exp_d, 1'b0} || lg_n - base !== 4)
            begin mismatched++; $display("FAIL drain_hold%0d got=%b/%h/stb%b/reads%0d exp=1/%h/stb0/reads4", c, m_valid, m_data, bus.M_STB_O, lg_n - base, exp_d); end
        end
      end
      m_ready = 1'b1;
      @(posedge clk);
      #1 m_ready = 1'b0;
    end
    compared++;
    if (lg_n - base !== 8) begin mismatched++; $display("FAIL drain_total got=%0d exp=8", lg_n - base); end
  endtask

  task automatic test_clear;
    int n = 0;
    while (!frame_done && n < 50) begin @(negedge clk); n++; end
    compared++;
    if ({frame_done, frame_count, busy} !== {1'b1, 16'd1, 1'b0}) begin mismatched++; $display("FAIL clear_status got=%b/%0d/%b exp=1/1/0", frame_done, frame_count, busy); end
    compared++;
    if ({lg_adr[lg_n-1], lg_we[lg_n-1], lg_dat[lg_n-1]} !== {B, 1'b1, 32'h2}) begin mismatched++; $display("FAIL clear_write got=%h/%b/%h exp=100/1/2", lg_adr[lg_n-1], lg_we[lg_n-1], lg_dat[lg_n-1]); end
    @(negedge clk);
    compared++;
    if (frame_done !== 1'b0) begin mismatched++; $display("FAIL clear_pulse got=%b exp=0", frame_done); end
  endtask

  task automatic test_delay_reset;
    int base = lg_n;
    int n = 0;
    int hs [3];
    ack_delay = 4;
    for (int i = 0; i < 3; i++) send(32'h0009_0000 + (32'(i) << 16), hs[i]);
    compared++;
    if ({lg_adr[base], lg_we[base], lg_dat[base]} !== {B, 1'b1, 32'h1}) begin mismatched++; $display("FAIL delay_start got=%h/%b/%h exp=100/1/1", lg_adr[base], lg_we[base], lg_dat[base]); end
    for (int i = 1; i < 3; i++) begin
      compared++;
      if ({lg_adr[base+i], lg_dat[base+i]} !== {B + 32'd4, 32'h0009_0000 + (32'(i - 1) << 16)})
        begin mismatched++; $display("FAIL delay_write%0d got=%h/%h", i, lg_adr[base+i], lg_dat[base+i]); end
      compared++;
      if (lg_ack[base+i] - lg_rise[base+i] !== 4) begin mismatched++; $display("FAIL delay_ack%0d got=%0d exp=4", i, lg_ack[base+i] - lg_rise[base+i]); end
    end
    compared++;
    if (hs[2] - hs[1] !== 7) begin mismatched++; $display("FAIL delay_ready_latency got=%0d exp=7", hs[2] - hs[1]); end
    s_data = 32'h000C_0000;
    s_valid = 1'b1;
    while (!bus.M_STB_O && n < 50) begin @(negedge clk); n++; end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({bus.M_STB_O, bus.M_CYC_O} !== 2'b00) begin mismatched++; $display("FAIL reset_abort_stb got=%b exp=00", {bus.M_STB_O, bus.M_CYC_O}); end
    compared++;
    if (dut.state_q !== IDLE || busy !== 1'b0 || frame_count !== 16'd0) begin mismatched++; $display("FAIL reset_abort_state got=%0d/%b/%0d exp=%0d/0/0", dut.state_q, busy, frame_count, IDLE); end
    compared++;
    if (lg_n - base !== 3) begin mismatched++; $display("FAIL reset_abort_log got=%0d exp=3", lg_n - base); end
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_feed();
    test_poll();
    test_drain();
    test_clear();
    test_delay_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/fft_wb_feeder.md
# fft_wb_feeder

Wishbone classic master that drives the FFT Wishbone slave. It sits directly upstream and downstream of that slave on the same bus. It accepts a stream of complex samples, starts a frame, writes N samples into the slave's data register, and polls the status register until the frame is done. It then reads the N results back out to an output stream and clears the core, so the datapath never needs a CPU in the loop.

## Interface
Parameters:
- WB_Width, 32, bus data width; real part in [WB_Width-1:WB_Width/2], imaginary part in [WB_Width/2-1:0]
- Adress_wordwidth, 32, bus address width
- N, 1024, FFT frame length in samples
- Log2N, 10, counter width; N = 2**Log2N
- BASE, 0, slave base address
- reg_control / reg_data / reg_status / reg_memory, 0 / 4 / 8 / 12, slave register offsets added to BASE
- POLL_GAP, 8, idle cycles between status reads

Ports:
- CLK_I  in  1  clock
- RST_I  in  1  reset; asynchronous, active-low
- M_ADR_O  out  Adress_wordwidth  bus address
- M_DAT_O  out  WB_Width  bus write data
- M_DAT_I  in  WB_Width  bus read data
- M_STB_O / M_CYC_O  out  1  strobe / cycle; always driven together
- M_WE_O  out  1  write enable
- M_ACK_I  in  1  slave acknowledge
- s_valid / s_ready  in / out  1  input sample handshake
- s_data  in  WB_Width  input sample
- m_valid / m_ready  out / in  1  result handshake
- m_data  out  WB_Width  result sample
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse when a frame fully completes
- frame_count  out  16  completed frames, wraps at 0xFFFF->0

## Operation
- FSM states: IDLE, START, FEED, POLL_WAIT, POLL, DRAIN, CLEAR.
- **IDLE**
  - s_ready is 0.
  - When s_valid is 1, go to START.
- **START**
  - Write 0x1 (enable) to BASE+reg_control.
  - On ACK, go to FEED with cnt=0.
- **FEED**
  - s_ready=1 only when no transaction is in flight.
  - An s_valid&s_ready handshake latches s_data into M_DAT_O and issues a write to BASE+reg_data.
  - On ACK, cnt++. When cnt reaches N-1 and is ACKed, go to POLL_WAIT.
- **POLL_WAIT**: count POLL_GAP cycles, then go to POLL.
- **POLL**
  - Read BASE+reg_status.
  - On ACK, if M_DAT_I[0]=1, go to DRAIN with cnt=0; otherwise go back to POLL_WAIT.
- **DRAIN**
  - Read BASE+reg_memory; the slave auto-increments its index.
  - On ACK, latch M_DAT_I into m_data and set m_valid.
  - The next read is not issued until m_valid&m_ready.
  - After the N-th result is accepted, go to CLEAR.
- **CLEAR**
  - Write 0x2 (clear) to BASE+reg_control.
  - On ACK, pulse frame_done, increment frame_count, and go to IDLE.
- Only one bus transaction is outstanding at a time.
- M_ACK_I is ignored while M_STB_O=0.
- cnt is Log2N bits wide; the terminal test is cnt==N-1, so no overflow is needed.

## Timing
- Reset values: all outputs 0; FSM in IDLE; cnt and frame_count 0.
- Asserting RST_I mid-frame aborts immediately: M_STB_O/M_CYC_O drop asynchronously and there is no bus cleanup.
- Bus transaction timing:
  - M_STB_O rises the cycle after the decision (a handshake, or entry to the state).
  - ADR, DAT, and WE are stable for the whole time STB is high.
  - STB falls the cycle after the ACK cycle, and stays low for at least one cycle between transactions.
- FEED latency: s handshake in cycle k puts STB high in k+1. With a zero-wait slave (ACK in k+1), s_ready returns in k+3.
- DRAIN latency: ACK in cycle k gives m_valid in k+1. m_data and m_valid are held until m_ready.
- frame_done is high for exactly the cycle after the CLEAR ACK.
- A slave stalling ACK indefinitely holds the FSM in place; there is no timeout.

## Structure
- Shared package holds:
  - the FSM state enum
  - CTRL_ENABLE=0x1, CTRL_CLEAR=0x2, STATUS_DONE_BIT=0
- One sub-module, fft_wb_master_port:
  - owns STB/CYC/WE/ADR/DAT registers and ACK capture
  - req/done interface to the FSM
- The FSM, counters, and stream handshakes live in the top level.

## Test plan
Bench setup: N=8, BASE=0x100, POLL_GAP=2, behavioural slave model.
- Reset with s_valid=1 held: all outputs 0; after release, a write of 0x1 to 0x100 is issued, then s_ready=1.
- Stream 8 samples 0x00010000..0x00080000 with a zero-wait slave: 8 writes to 0x104 in order; STB low for ≥1 cycle between writes; FSM enters POLL_WAIT.
- Slave reports status 0 twice, then 1: exactly 3 reads of 0x108 spaced ≥2 idle cycles apart; DRAIN starts after the third.
- DRAIN with m_ready low for 5 cycles on result 3: m_data held stable; no bus read issued until accepted; the 8 results match the slave memory contents.
- Full frame: write 0x2 to 0x100, frame_done pulses one cycle, frame_count=1, busy=0.
- Slave ACK delayed 4 cycles on every access, then RST_I asserted mid-FEED: correct ordering during the delays; on reset, STB drops the same cycle and the FSM returns to IDLE.
